spi_regs_burst: RTL and testbench

Parametrised SPI-mode-0 slave with an internal register file, the successor to the fixed 16-bit single-access SPI register slave. Adds configurable address/data widths, burst transfers with address auto-increment and wrap, a read-only register window fed by hardware, and per-word write strobes to the core. It sits between the chip's SPI pins and the core configuration/status logic and runs on the system clock, oversampling `sclk`, `ss_n` and `mosi`.

---
 rtl/spi_regs_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_regs_burst.sv | 191 +++++++++++++++++++
 tb/tb_spi_regs_burst.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_regs_pkg.sv
// Shared types and constants for the burst-capable SPI register slave.
package spi_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus an edge-detect flop. Resets low so a pin that is
// already low at reset release never produces a falling edge.
module spi_sync_edge
  import spi_regs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_regs_burst.sv
// SPI mode-0 register slave with burst auto-increment, a hardware-fed
// read-only window and per-word write strobes, oversampled on clk.
module spi_regs_burst
  import spi_regs_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 128,
  parameter int RW_REGS  = 112
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ss_n,
  input  logic                                 sclk,
  input  logic                                 mosi,
  output logic                                 miso,
  input  logic [(NUM_REGS-RW_REGS)*DATA_W-1:0] ro_i,
  output logic [RW_REGS*DATA_W-1:0]            regs_o,
  output logic                                 wr_stb_o,
  output logic [ADDR_W-1:0]                    wr_addr_o,
  output logic [DATA_W-1:0]                    wr_data_o,
  output logic                                 busy_o
);

  localparam int HDR_W   = 1 + ADDR_W;
  localparam int SH_W    = max_int(HDR_W, DATA_W);
  localparam int CNT_W   = $clog2(SH_W);
  localparam int RO_REGS = NUM_REGS - RW_REGS;
  localparam logic [ADDR_W:0]   RW_LIM    = (ADDR_W+1)'(RW_REGS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

  function automatic logic [ADDR_W-1:0] addr_mod(input logic [ADDR_W-1:0] a);
    return ADDR_W'({1'b0, a} % (ADDR_W+1)'(NUM_REGS));
  endfunction

  logic sclk_unused_s, sclk_rise_s, sclk_fall_s;
  logic ss_s, ss_rise_unused_s, ss_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_e state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [SH_W-2:0]   rx_q;
  logic [SH_W-1:0]   rx_d_s;
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] addr_q, hdr_addr_s, addr_inc_s, rd_addr_s;
  logic              rw_q, hdr_rw_s;
  logic              miso_q;
  logic              hdr_done_s, word_done_s, commit_s;
  logic [DATA_W-1:0] regs_q [RW_REGS];
  logic [DATA_W-1:0] words_s [NUM_REGS];
  logic [DATA_W-1:0] rd_word_s;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sclk),
    .q_o    (sclk_unused_s),
    .rise_o (sclk_rise_s),
    .fall_o (sclk_fall_s)
  );

  spi_sync_edge u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ss_n),
    .q_o    (ss_s),
    .rise_o (ss_rise_unused_s),
    .fall_o (ss_fall_s)
  );

  // mosi gets the same depth as sclk so the sampled bit lines up with the rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  for (genvar k = 0; k < RW_REGS; k++) begin : g_rw_words
    assign words_s[k] = regs_q[k];
    assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
  end
  for (genvar k = 0; k < RO_REGS; k++) begin : g_ro_words
    assign words_s[RW_REGS+k] = ro_i[k*DATA_W +: DATA_W];
  end

  assign rx_d_s     = {rx_q, mosi_s};
  assign hdr_rw_s   = rx_d_s[HDR_W-1];
  assign hdr_addr_s = addr_mod(rx_d_s[ADDR_W-1:0]);
  assign addr_inc_s = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
  // Prefetch target: the header address at header end, else the next burst address
  assign rd_addr_s  = (state_q == ST_HDR) ? hdr_addr_s : addr_inc_s;
  assign rd_word_s  = words_s[rd_addr_s];
  assign commit_s   = word_done_s && (rw_q == RW_WRITE) && ({1'b0, addr_q} < RW_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall_s) state_d = ST_HDR;  else state_d = ST_IDLE;
      ST_HDR:  if (ss_s)      state_d = ST_IDLE;
               else if (hdr_done_s) state_d = ST_DATA;
               else state_d = ST_HDR;
      ST_DATA: if (ss_s)      state_d = ST_IDLE; else state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_done_s  = 1'b0;
    word_done_s = 1'b0;
    case (state_q)
      ST_HDR:  hdr_done_s  = sclk_rise_s && (bit_cnt_q == CNT_W'(HDR_W - 1));
      ST_DATA: word_done_s = sclk_rise_s && (bit_cnt_q == CNT_W'(DATA_W - 1));
      default: begin
        hdr_done_s  = 1'b0;
        word_done_s = 1'b0;
      end
    endcase
  end

  // Shift, count and address datapath; a completing rise still commits on frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rw_q      <= RW_READ;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int k = 0; k < RW_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_stb_q  <= commit_s;
      wr_addr_q <= commit_s ? addr_q : '0;
      wr_data_q <= commit_s ? rx_d_s[DATA_W-1:0] : '0;
      if (commit_s) begin
        regs_q[addr_q] <= rx_d_s[DATA_W-1:0];
      end
      if (state_d == ST_IDLE) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
        tx_q      <= '0;
        miso_q    <= 1'b0;
      end else if (sclk_rise_s) begin
        rx_q <= rx_d_s[SH_W-2:0];
        if (hdr_done_s) begin
          bit_cnt_q <= '0;
          rw_q      <= hdr_rw_s;
          addr_q    <= hdr_addr_s;
          tx_q      <= rd_word_s;
        end else if (word_done_s) begin
          bit_cnt_q <= '0;
          addr_q    <= addr_inc_s;
          tx_q      <= rd_word_s;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end else if (sclk_fall_s) begin
        if ((state_q == ST_DATA) && (rw_q == RW_READ)) begin
          miso_q <= tx_q[DATA_W-1];
          tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign miso      = miso_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_regs_burst.sv
// Directed bench for spi_regs_burst: SPI master tasks plus a strobe monitor.
module tb_spi_regs_burst;

  logic         clk = 1'b0;
  logic         rst_n, ss_n, sclk, mosi;
  logic         miso;
  logic [127:0] ro_i;
  logic [895:0] regs_o;
  logic         wr_stb_o;
  logic [6:0]   wr_addr_o;
  logic [7:0]   wr_data_o;
  logic         busy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  int         stb_cnt = 0;
  logic [6:0] stb_addr = 7'h00;
  logic [7:0] stb_data = 8'h00;
  logic [7:0] stb_reg = 8'h00;

  spi_regs_burst dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (ss_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ro_i      (ro_i),
    .regs_o    (regs_o),
    .wr_stb_o  (wr_stb_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb_o) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= wr_addr_o;
      stb_data <= wr_data_o;
      stb_reg  <= regs_o[int'(wr_addr_o)*8 +: 8];
    end
  end

  function automatic logic [7:0] reg_at(input int a);
    return regs_o[a*8 +: 8];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(8);
      sclk = 1'b1;
      rx[i] = miso;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] tx, input int n, output logic [31:0] rx);
    ss_n = 1'b0;
    wait_clk(8);
    spi_bits(tx, n, rx);
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_reset;
    wait_clk(3);
    total_cnt++; if (regs_o !== 896'h0) $display("FAIL reset_regs got=%0h exp=0", regs_o); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso); else pass_cnt++;
    total_cnt++; if (wr_stb_o !== 1'b0) $display("FAIL reset_stb got=%b exp=0", wr_stb_o); else pass_cnt++;
    total_cnt++; if (wr_addr_o !== 7'h00) $display("FAIL reset_waddr got=%h exp=00", wr_addr_o); else pass_cnt++;
    total_cnt++; if (wr_data_o !== 8'h00) $display("FAIL reset_wdata got=%h exp=00", wr_data_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else pass_cnt++;
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_single_write;
    logic [31:0] rx;
    int s0;
    s0 = stb_cnt;
    frame(32'h0000_923A, 16, rx);
    total_cnt++; if (reg_at(8'h12) !== 8'h3A) $display("FAIL wr_reg12 got=%h exp=3a", reg_at(8'h12)); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL wr_stb_count got=%0d exp=1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_addr !== 7'h12) $display("FAIL wr_stb_addr got=%h exp=12", stb_addr); else pass_cnt++;
    total_cnt++; if (stb_data !== 8'h3A) $display("FAIL wr_stb_data got=%h exp=3a", stb_data); else pass_cnt++;
    total_cnt++; if (stb_reg !== 8'h3A) $display("FAIL wr_reg_at_stb got=%h exp=3a", stb_reg); else pass_cnt++;
  endtask

  task automatic test_single_read;
    logic [31:0] rx;
    frame(32'h0000_1200, 16, rx);
    total_cnt++; if (rx[7:0] !== 8'h3A) $display("FAIL rd_data got=%h exp=3a", rx[7:0]); else pass_cnt++;
    total_cnt++; if (rx[15:8] !== 8'h00) $display("FAIL rd_hdr_miso got=%h exp=00", rx[15:8]); else pass_cnt++;
  endtask

  task automatic test_burst_write;
    logic [31:0] rx;
    int s0;
    s0 = stb_cnt;
    frame(32'hEE11_2233, 32, rx);
    total_cnt++; if (reg_at(8'h6E) !== 8'h11) $display("FAIL burst_reg6e got=%h exp=11", reg_at(8'h6E)); else pass_cnt++;
    total_cnt++; if (reg_at(8'h6F) !== 8'h22) $display("FAIL burst_reg6f got=%h exp=22", reg_at(8'h6F)); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 2) $display("FAIL burst_stb_count got=%0d exp=2", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_addr !== 7'h6F) $display("FAIL burst_last_addr got=%h exp=6f", stb_addr); else pass_cnt++;
    frame(32'h0000_0000 | 32'h006E_0000, 24, rx);
    total_cnt++; if (rx[15:8] !== 8'h11) $display("FAIL burst_rd0 got=%h exp=11", rx[15:8]); else pass_cnt++;
    total_cnt++; if (rx[7:0] !== 8'h22) $display("FAIL burst_rd1 got=%h exp=22", rx[7:0]); else pass_cnt++;
  endtask

  task automatic test_burst_wrap;
    logic [31:0] rx;
    int s0;
    s0 = stb_cnt;
    frame(32'h00FF_9955, 24, rx);
    total_cnt++; if (reg_at(0) !== 8'h55) $display("FAIL wrap_reg00 got=%h exp=55", reg_at(0)); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL wrap_stb_count got=%0d exp=1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_addr !== 7'h00) $display("FAIL wrap_stb_addr got=%h exp=00", stb_addr); else pass_cnt++;
    frame(32'h007F_0000, 24, rx);
    total_cnt++; if (rx[23:16] !== 8'h00) $display("FAIL wrap_rd_hdr got=%h exp=00", rx[23:16]); else pass_cnt++;
    total_cnt++; if (rx[15:8] !== 8'h3C) $display("FAIL wrap_rd7f got=%h exp=3c", rx[15:8]); else pass_cnt++;
    total_cnt++; if (rx[7:0] !== 8'h55) $display("FAIL wrap_rd00 got=%h exp=55", rx[7:0]); else pass_cnt++;
  endtask

  task automatic test_ro_window;
    logic [31:0] rx;
    int s0;
    s0 = stb_cnt;
    frame(32'h0000_F05A, 16, rx);
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL ro_write_stb got=%0d exp=0", stb_cnt - s0); else pass_cnt++;
    frame(32'h0000_7000, 16, rx);
    total_cnt++; if (rx[7:0] !== 8'hA5) $display("FAIL ro_read got=%h exp=a5", rx[7:0]); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL ro_idle_miso got=%b exp=0", miso); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [31:0] rx;
    int s0;
    frame(32'h0000_8577, 16, rx);
    s0 = stb_cnt;
    ss_n = 1'b0;
    wait_clk(8);
    spi_bits(32'h0000_085F, 12, rx);
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(10);
    total_cnt++; if (reg_at(5) !== 8'h77) $display("FAIL abort_reg05 got=%h exp=77", reg_at(5)); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL abort_stb got=%0d exp=0", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL abort_miso got=%b exp=0", miso); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rx;
    int s0;
    ss_n = 1'b0;
    wait_clk(8);
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy_o); else pass_cnt++;
    spi_bits(32'h0000_A044, 16, rx);
    spi_bits(32'h0000_000F, 4, rx);
    rst_n = 1'b0;
    wait_clk(2);
    total_cnt++; if (regs_o !== 896'h0) $display("FAIL mid_rst_regs got=%0h exp=0", regs_o); else pass_cnt++;
    total_cnt++; if (miso !== 1'b0) $display("FAIL mid_rst_miso got=%b exp=0", miso); else pass_cnt++;
    total_cnt++; if (wr_stb_o !== 1'b0) $display("FAIL mid_rst_stb got=%b exp=0", wr_stb_o); else pass_cnt++;
    total_cnt++; if (wr_addr_o !== 7'h00) $display("FAIL mid_rst_waddr got=%h exp=00", wr_addr_o); else pass_cnt++;
    total_cnt++; if (wr_data_o !== 8'h00) $display("FAIL mid_rst_wdata got=%h exp=00", wr_data_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy_o); else pass_cnt++;
    rst_n = 1'b1;
    wait_clk(8);
    s0 = stb_cnt;
    spi_bits(32'h0000_00FF, 8, rx);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL dead_busy got=%b exp=0", busy_o); else pass_cnt++;
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(10);
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL dead_stb got=%0d exp=0", stb_cnt - s0); else pass_cnt++;
    frame(32'h0000_B3C3, 16, rx);
    total_cnt++; if (reg_at(8'h33) !== 8'hC3) $display("FAIL post_rst_reg33 got=%h exp=c3", reg_at(8'h33)); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL post_rst_stb got=%0d exp=1", stb_cnt - s0); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    ss_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ro_i  = 128'h0;
    ro_i[7:0]     = 8'hA5;
    ro_i[15:8]    = 8'hFF;
    ro_i[127:120] = 8'h3C;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_burst_wrap();
    test_ro_window();
    test_abort();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
